// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined WIDTH-bit bitwise logic unit with accumulator
// Optional build macro LOGIC_UNIT_FLAGS_EN adds registered out_zero / out_parity result flags.
module logic_unit_pipe #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    // Stage 1 holding registers
    logic             s1_valid_q,  s1_valid_d;
    logic [2:0]       s1_op_q,     s1_op_d;
    logic             s1_acc_en_q, s1_acc_en_d;
    logic [WIDTH-1:0] s1_a_q,      s1_a_d;
    logic [WIDTH-1:0] s1_b_q,      s1_b_d;

    // Stage 2 / output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;

    // Accumulator: always the most recently computed result (or ACC_INIT after clear/reset)
    logic [WIDTH-1:0] acc_q,       acc_d;

`ifdef LOGIC_UNIT_FLAGS_EN
    logic             zero_q,      zero_d;
    logic             parity_q,    parity_d;
`endif

    logic             s2_take;
    logic             s1_move;
    logic             in_fire;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] calc;

    // Handshake / advance conditions; in_ready deliberately ignores in_valid
    always_comb begin
        s2_take  = !out_valid_q || out_ready;
        s1_move  = s1_valid_q && s2_take;
        in_ready = !s1_valid_q || s2_take;
        in_fire  = in_valid && in_ready;
    end

    // S2 compute: operand a is resolved here so chained accumulates see the latest result
    always_comb begin
        a_eff = s1_acc_en_q ? acc_q : s1_a_q;
        case (s1_op_q)
            OP_AND:  calc = a_eff & s1_b_q;
            OP_OR:   calc = a_eff | s1_b_q;
            OP_NOT:  calc = ~a_eff;
            OP_NAND: calc = ~(a_eff & s1_b_q);
            OP_NOR:  calc = ~(a_eff | s1_b_q);
            OP_XOR:  calc = a_eff ^ s1_b_q;
            OP_XNOR: calc = ~(a_eff ^ s1_b_q);
            default: calc = s1_b_q;
        endcase
    end

    // Stage 1 next state: load on input handshake, empty when its contents move on
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_acc_en_d = s1_acc_en_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_op_d     = op;
            s1_acc_en_d = acc_en;
            s1_a_d      = a;
            s1_b_d      = b;
        end else if (s1_move) begin
            s1_valid_d  = 1'b0;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 3'd0;
            s1_acc_en_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_acc_en_q <= s1_acc_en_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
        end
    end

    // Stage 2 next state: output holds under backpressure, refills whenever it can take
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (s2_take) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_move) begin
            result_d = calc;
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    // Accumulator next state: clear wins over the write-back of a colliding compute
    always_comb begin
        acc_d = acc_q;
        if (s1_move) begin
            acc_d = calc;
        end
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= ACC_INIT;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Flag next state: captured with the result so they stay aligned under backpressure
    always_comb begin
        zero_d   = zero_q;
        parity_d = parity_q;
        if (s1_move) begin
            zero_d   = ~|calc;
            parity_d = ^calc;
        end
    end

    // Flag registers; reset values describe the all-zero reset result
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign out_zero   = zero_q;
    assign out_parity = parity_q;
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit: all seven basic gate functions plus pass-through on WIDTH-bit operands, selected per transaction by an opcode.
- Two-stage registered pipeline with valid/ready handshakes on input and output.
- Optional accumulate mode chains results through an internal accumulator.
- Used as the general logic datapath element wherever the fixed 1-bit gate set is too narrow.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- ACC_INIT, 0, accumulator value after reset and after acc_clr (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction offered
- in_ready  output  1  unit can accept an input this cycle
- op  input  3  opcode: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS(b)
- acc_en  input  1  replace operand a with the accumulator for this transaction
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- acc_clr  input  1  load ACC_INIT into the accumulator
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rst.
- Reset values: s1_valid=0, out_valid=0, result=0, accumulator=ACC_INIT. in_ready=1 in the cycle after reset.
- Stage 1 (S1) registers op, acc_en, a and b on an input handshake (in_valid && in_ready).
- Stage 2 (S2) computes the selected function bitwise over WIDTH bits and registers it into result/out_valid.
- Advance rules:
  - s2_take = !out_valid || out_ready
  - s1_move = s1_valid && s2_take
  - in_ready = !s1_valid || s2_take (combinational; no dependency on in_valid)
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 transaction per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, result and out_valid hold stable. S1 holds its contents. in_ready=0 once S1 is full.
- Data is never dropped or duplicated. Results leave in input order.
- Operand a resolution happens at S2 compute time: a_eff = s1_acc_en ? accumulator : s1_a. NOT ignores b. PASS ignores a_eff.
- Accumulator update:
  - Updated with the computed value on every s1_move, regardless of acc_en.
  - It therefore always holds the most recently computed result, and back-to-back accumulate transactions chain correctly with no hazard.
- acc_clr:
  - Loads ACC_INIT at the clock edge.
  - If acc_clr and s1_move occur in the same cycle, the S2 compute uses the pre-clear accumulator, and acc_clr wins the accumulator write.
- Mid-operation reset: rst flushes S1 and S2 in one cycle; in-flight transactions are discarded, never emitted. rst has priority over every other input.
- Simultaneous output consume and new S2 load in one cycle (out_valid && out_ready && s1_valid): result is replaced and out_valid stays 1.
- Width rule: all operations are strictly bitwise. No carries, no sign extension.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- When defined, two extra outputs are added:
  - out_zero (1 bit) = (result == 0)
  - out_parity (1 bit) = XOR-reduction of result
- Both flags are registered alongside result in S2, are valid exactly when out_valid=1, reset to 1 and 0 respectively, and hold under backpressure.
- When not defined, the ports do not exist and behaviour is otherwise identical.

Test Plan:
- Opcode sweep: WIDTH=8, a=8'hC5, b=8'h3A, out_ready=1, op 0..7 back-to-back → results 00, FF, 3A, FF, 00, FF, 00, 3A, each 2 cycles after its handshake, one per cycle.
- Accumulate chain: acc_clr, then op=5 (XOR) with acc_en=1, b=01, 02, 04 back-to-back → results 01, 03, 07; final accumulator 07.
- Backpressure: out_ready=0 for 5 cycles with 3 inputs offered → first result held stable, in_ready drops after the second accept, the third input is not accepted. Releasing out_ready delivers both accepted results in order with no loss.
- Mid-stream reset: rst asserted while S1 and S2 are both valid → next cycle out_valid=0, in_ready=1, accumulator=ACC_INIT, no stale result emitted afterwards.
- acc_clr collision: acc_clr together with an accumulating XOR (accumulator=0F, b=F0) → emitted result FF, accumulator = ACC_INIT afterwards.
- Flags (macro defined): result 00 → out_zero=1, out_parity=0. Result 07 → out_zero=0, out_parity=1.
